// File: rtl/serial_twos_complement.sv
// Bit-serial two's-complement negator: copies bits up to and including the first 1,
// then inverts the rest. It also assembles each completed frame into a parallel word.
module serial_twos_complement #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   output logic             out_bit,
   output logic             out_last,
   input  logic             out_ready,
   output logic             par_valid,
   output logic [WIDTH-1:0] par_data,
   output logic             ovf,
   output logic             busy
);

   localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

   typedef enum logic {
      COPY   = 1'b0,
      INVERT = 1'b1
   } state_t;

   state_t           state_r;
   state_t           state_next_s;
   logic [CW-1:0]    cnt_r;
   logic [WIDTH-1:0] shift_r;
   logic             out_valid_r;
   logic             out_bit_r;
   logic             out_last_r;
   logic             par_valid_r;
   logic [WIDTH-1:0] par_data_r;
   logic             ovf_r;
   logic             in_ready_s;
   logic             accept_s;
   logic             last_s;
   logic             prod_bit_s;

   // Handshake decode and the bit produced for the current input.
   always_comb begin
      in_ready_s = 1'b0;
      if (clr) begin
         in_ready_s = 1'b0;
      end else begin
         in_ready_s = ~out_valid_r | out_ready;
      end
      accept_s   = in_valid & in_ready_s;
      last_s     = (cnt_r == LAST_CNT);
      prod_bit_s = (state_r == INVERT) ? ~in_bit : in_bit;
   end

   // Next-state logic; the first accepted 1 of a frame switches to INVERT.
   always_comb begin
      state_next_s = state_r;
      if (clr) begin
         state_next_s = COPY;
      end else if (accept_s) begin
         if (last_s) begin
            state_next_s = COPY;
         end else if (in_bit) begin
            state_next_s = INVERT;
         end else begin
            state_next_s = state_r;
         end
      end else begin
         state_next_s = state_r;
      end
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= COPY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Bit counter and partial-result shift register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r   <= {CW{1'b0}};
         shift_r <= {WIDTH{1'b0}};
      end else if (clr) begin
         cnt_r   <= {CW{1'b0}};
         shift_r <= {WIDTH{1'b0}};
      end else if (accept_s) begin
         shift_r[cnt_r] <= prod_bit_s;
         if (last_s) begin
            cnt_r <= {CW{1'b0}};
         end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
         end
      end else begin
         cnt_r   <= cnt_r;
         shift_r <= shift_r;
      end
   end

   // Single-entry output register; held while the consumer stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_r <= 1'b0;
         out_bit_r   <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (clr) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else if (accept_s) begin
         out_valid_r <= 1'b1;
         out_bit_r   <= prod_bit_s;
         out_last_r  <= last_s;
      end else if (out_valid_r && out_ready) begin
         out_valid_r <= 1'b0;
         out_last_r  <= 1'b0;
      end else begin
         out_valid_r <= out_valid_r;
      end
   end

   // Parallel result and overflow flag; they survive a clr so the last frame stays readable.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         par_valid_r <= 1'b0;
         par_data_r  <= {WIDTH{1'b0}};
         ovf_r       <= 1'b0;
      end else if (accept_s && last_s) begin
         par_valid_r <= 1'b1;
         par_data_r  <= {prod_bit_s, shift_r[WIDTH-2:0]};
         ovf_r       <= (state_r == COPY) & in_bit;
      end else begin
         par_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_valid = out_valid_r;
   assign out_bit   = out_bit_r;
   assign out_last  = out_last_r;
   assign par_valid = par_valid_r;
   assign par_data  = par_data_r;
   assign ovf       = ovf_r;
   assign busy      = (cnt_r != {CW{1'b0}});

endmodule

// File: doc/serial_twos_complement.md
SERIAL_TWOS_COMPLEMENT -- requirements
Module: serial_twos_complement

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the frame length in bits (WIDTH >= 2).
REQ-002 Port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n SHALL be an input, 1 bit wide: asynchronous, active-low reset.
REQ-004 Port clr SHALL be an input, 1 bit wide: synchronous frame abort.
REQ-005 Port in_valid SHALL be an input, 1 bit wide: in_bit is valid.
REQ-006 Port in_bit SHALL be an input, 1 bit wide: serial operand, LSB first.
REQ-007 Port in_ready SHALL be an output, 1 bit wide: the block can accept in_bit this cycle.
REQ-008 Port out_valid SHALL be an output, 1 bit wide: out_bit is valid.
REQ-009 Port out_bit SHALL be an output, 1 bit wide: serial two's-complement result, LSB first.
REQ-010 Port out_last SHALL be an output, 1 bit wide: out_bit is the frame MSB.
REQ-011 Port out_ready SHALL be an input, 1 bit wide: the downstream stage accepts out_bit.
REQ-012 Port par_valid SHALL be an output, 1 bit wide: one-cycle pulse, par_data updated.
REQ-013 Port par_data SHALL be an output, WIDTH bits wide: last completed result, parallel.
REQ-014 Port ovf SHALL be an output, 1 bit wide: the last frame was the most-negative value (10..0).
REQ-015 Port busy SHALL be an output, 1 bit wide: a frame is partially accepted (bit counter != 0).

Function
REQ-016 The transfer rule SHALL be: input accepted when in_valid & in_ready; output consumed when out_valid & out_ready.
REQ-017 in_ready SHALL equal ~out_valid | out_ready (single-entry output register; combinational path out_ready->in_ready only).
REQ-018 The FSM SHALL have two states: COPY (no 1 seen in frame yet) and INVERT.
REQ-019 In COPY, an accepted bit b SHALL produce out_bit=b; if b=1, the next state SHALL be INVERT.
REQ-020 In INVERT, an accepted bit b SHALL produce out_bit=~b; the state SHALL stay INVERT.
REQ-021 Latency SHALL be 1 cycle: the bit accepted at edge N is presented on out_bit/out_valid after edge N.
REQ-022 out_bit, out_valid and out_last SHALL hold stable while out_valid & ~out_ready.
REQ-023 out_valid SHALL clear after consumption unless a new bit is accepted on the same edge.
REQ-024 The bit counter SHALL run 0..WIDTH-1 and increment per accepted bit.
REQ-025 At count WIDTH-1, the counter SHALL wrap to 0, the FSM SHALL return to COPY, and out_last SHALL be set with that bit.
REQ-026 The result shift register SHALL collect each produced bit at position = count.
REQ-027 On the accept of the last bit, par_data SHALL load the full result and par_valid SHALL pulse high for exactly 1 cycle, aligned with out_last's first cycle.
REQ-028 par_data and ovf SHALL hold until the next completed frame.
REQ-029 ovf SHALL be set when the last bit is accepted in COPY with value 1; otherwise it SHALL be cleared at frame completion.
REQ-030 An all-zero frame SHALL produce all-zero output with ovf=0.
REQ-031 Back-to-back frames SHALL be supported with no idle cycle between them.
REQ-032 clr=1 SHALL reset the counter to 0, the FSM to COPY, out_valid to 0, and discard the partial shift register; par_data and ovf SHALL be unchanged.
REQ-033 An input offered in the same cycle as clr SHALL be dropped, and in_ready SHALL read 0 while clr=1.

Reset
REQ-034 While rst_n=0, the block SHALL asynchronously force: FSM=COPY, counter=0, out_valid=0, out_bit=0, out_last=0, par_valid=0, par_data=0, ovf=0, busy=0.
REQ-035 Reset mid-frame SHALL discard the partial frame, and the first bit accepted after release SHALL be treated as bit 0.
REQ-036 in_ready SHALL be 1 from the first cycle after reset release.

Verification (WIDTH=8, out_ready=1 unless stated)
REQ-037 Scenario: input 0x05 (1,0,1,0,0,0,0,0) -> out stream 1,1,0,1,1,1,1,1; par_data=0xFB, par_valid for 1 cycle, ovf=0.
REQ-038 Scenario: input 0x00 -> out stream all 0; par_data=0x00, ovf=0; FSM stays COPY throughout.
REQ-039 Scenario: input 0x80 -> par_data=0x80, ovf=1; then input 0x01 -> par_data=0xFF, ovf=0 (back-to-back, no gap).
REQ-040 Scenario: input 0x3C with out_ready=0 for 3 cycles after bit 2 -> in_ready=0, out_bit held; final stream = 0xC4, no bit lost or duplicated.
REQ-041 Scenario: rst_n pulsed low after 3 bits of 0xFF -> all outputs 0 immediately; next frame 0x01 -> par_data=0xFF.
REQ-042 Scenario: clr=1 together with in_valid at bit 4 of 0x10 -> bit dropped, busy=0, prior par_data unchanged; next frame 0x02 -> par_data=0xFE.
